// File: rtl/bsc_mmu_ptw_dmem_req_tracker.sv
// bsc_mmu_ptw_dmem_req_tracker
// Single-outstanding request tracker between the PTW dmem port and the HPDC
// adapter. Holds the request (and its address) stable from capture until the
// matching response returns, discards responses belonging to a flushed walk.
// Optional feature macro: MMU_PTW_DMEM_TIMEOUT_EN adds a WAIT-state response
// timeout that returns a nack to the PTW and pulses timeout_o.
//
// Handshake semantics (both sides): a request transfers in a cycle where
// req.valid and dmem_ready are both high; valid, once raised downstream, is held
// with a stable payload until dmem_ready is seen and is only withdrawn by flush.
// resp.valid is a single-cycle qualifier with no backpressure.

package bsc_mmu_ptw_dmem_pkg;

    typedef struct packed {
        logic        valid;
        logic [39:0] addr;
        logic [4:0]  cmd;
        logic [3:0]  typ;
        logic [63:0] data;
    } ptw_dmem_req_t;

    typedef struct packed {
        ptw_dmem_req_t req;
    } ptw_dmem_comm_t;

    typedef struct packed {
        logic        valid;
        logic        nack;
        logic [63:0] data;
    } dmem_ptw_resp_t;

    typedef struct packed {
        logic           dmem_ready;
        dmem_ptw_resp_t resp;
    } dmem_ptw_comm_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } trk_state_e;

endpackage

module bsc_mmu_ptw_dmem_req_tracker
    import bsc_mmu_ptw_dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  ptw_dmem_comm_t ptw_dmem_comm_i,
    output dmem_ptw_comm_t dmem_ptw_comm_o,
    output ptw_dmem_comm_t ptw_dmem_comm_o,
    input  dmem_ptw_comm_t dmem_ptw_comm_i,
    input  logic           flush_i,
    output logic           busy_o,
    output logic           timeout_o,
    output trk_state_e     state_dbg_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    trk_state_e    state_q, state_d;
    ptw_dmem_req_t hreq_q;
    logic          capture;
    logic          down_valid;
    logic          fwd_resp;
    logic          timeout;

`ifdef MMU_PTW_DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // WAIT-cycle counter: cleared on the downstream handshake, saturating count while waiting
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (state_q == ST_REQ && state_d == ST_WAIT) begin
            cnt_q <= '0;
        end else if (state_q == ST_WAIT && state_d == ST_WAIT && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A response or a flush in the same cycle takes priority over the timeout
    assign timeout = (state_q == ST_WAIT) && !dmem_ptw_comm_i.resp.valid && !flush_i &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Held request: captured on PTW acceptance, stable through REQ, WAIT and DRAIN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hreq_q <= '0;
        end else if (capture) begin
            hreq_q <= ptw_dmem_comm_i.req;
        end
    end

    // Next-state logic and per-state control strobes
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        down_valid = 1'b0;
        fwd_resp   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ptw_dmem_comm_i.req.valid && !flush_i) begin
                    capture = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    down_valid = 1'b1;
                    if (dmem_ptw_comm_i.dmem_ready) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_ptw_comm_i.resp.valid) begin
                    fwd_resp = !flush_i;
                    state_d  = ST_IDLE;
                end else if (flush_i || timeout) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dmem_ptw_comm_i.resp.valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output drive: held request downstream, gated response or timeout nack upstream
    always_comb begin
        ptw_dmem_comm_o           = '0;
        ptw_dmem_comm_o.req       = hreq_q;
        ptw_dmem_comm_o.req.valid = down_valid & hreq_q.valid;

        dmem_ptw_comm_o            = '0;
        dmem_ptw_comm_o.dmem_ready = (state_q == ST_IDLE);
        if (fwd_resp) begin
            dmem_ptw_comm_o.resp = dmem_ptw_comm_i.resp;
        end else if (timeout) begin
            dmem_ptw_comm_o.resp.valid = 1'b1;
            dmem_ptw_comm_o.resp.nack  = 1'b1;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign timeout_o   = timeout;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_bsc_mmu_ptw_dmem_req_tracker.sv
// Bench for bsc_mmu_ptw_dmem_req_tracker: directed scenarios followed by a
// randomized run, all checked each cycle against a transaction-level model.
module tb_bsc_mmu_ptw_dmem_req_tracker;
  import bsc_mmu_ptw_dmem_pkg::*;

  localparam int T = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;
  logic flush;
  ptw_dmem_comm_t ptw_in, ptw_out;
  dmem_ptw_comm_t dm_in, dm_out;
  logic busy, tmo;
  trk_state_e st;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bsc_mmu_ptw_dmem_req_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .ptw_dmem_comm_i (ptw_in),
    .dmem_ptw_comm_o (dm_out),
    .ptw_dmem_comm_o (ptw_out),
    .dmem_ptw_comm_i (dm_in),
    .flush_i         (flush),
    .busy_o          (busy),
    .timeout_o       (tmo),
    .state_dbg_o     (st)
  );

  // ---------------- scoreboard counters ----------------
  int nvec = 0;
  int nerr = 0;

  // ---------------- reference model ----------------
  // One access at a time: has_access = an access is owned by the tracker,
  // sent = adapter has accepted it, killed = its response will be thrown away.
  bit            has_access;
  bit            sent;
  bit            killed;
  int            waited;
  ptw_dmem_req_t held;

  function automatic void model_reset();
    has_access = 1'b0;
    sent       = 1'b0;
    killed     = 1'b0;
    waited     = 0;
    held       = '0;
  endfunction

  function automatic bit model_timeout();
`ifdef MMU_PTW_DMEM_TIMEOUT_EN
    return has_access && sent && !killed && !dm_in.resp.valid && !flush && (waited == T - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle: compare every output with what the model predicts
  task automatic settle();
    dmem_ptw_resp_t er;
    bit fwd;
    bit to;
    #4;
    fwd = has_access && sent && !killed && dm_in.resp.valid && !flush;
    to  = model_timeout();
    er  = '0;
    if (fwd) er = dm_in.resp;
    else if (to) begin
      er.valid = 1'b1;
      er.nack  = 1'b1;
    end
    chk("up_ready",   dm_out.dmem_ready, !has_access);
    chk("down_valid", ptw_out.req.valid, has_access && !sent && !flush);
    chk("down_addr",  ptw_out.req.addr,  held.addr);
    chk("down_cmd",   ptw_out.req.cmd,   held.cmd);
    chk("down_data",  ptw_out.req.data,  held.data);
    chk("up_resp",    dm_out.resp,       er);
    chk("busy",       busy,              has_access);
    chk("timeout",    tmo,               to);
  endtask

  // Advance one clock and update the model from the inputs of that cycle
  task automatic tick();
    bit to;
    @(posedge clk);
    to = model_timeout();
    if (!has_access) begin
      if (ptw_in.req.valid && !flush) begin
        has_access = 1'b1;
        sent       = 1'b0;
        killed     = 1'b0;
        held       = ptw_in.req;
      end
    end else if (!sent) begin
      if (flush) has_access = 1'b0;
      else if (dm_in.dmem_ready) begin
        sent   = 1'b1;
        waited = 0;
      end
    end else begin
      if (dm_in.resp.valid) has_access = 1'b0;
      else if (!killed) begin
        if (flush || to) killed = 1'b1;
        else waited++;
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input bit v, input logic [39:0] a, input logic [4:0] c,
                           input logic [63:0] d);
    ptw_in           = '0;
    ptw_in.req.valid = v;
    ptw_in.req.addr  = a;
    ptw_in.req.cmd   = c;
    ptw_in.req.typ   = 4'h3;
    ptw_in.req.data  = d;
  endtask

  task automatic drive_dm(input bit rdy, input bit rv, input logic [63:0] rd);
    dm_in            = '0;
    dm_in.dmem_ready = rdy;
    dm_in.resp.valid = rv;
    dm_in.resp.data  = rd;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_req(1'b0, '0, '0, '0);
      drive_dm(1'b0, 1'b0, '0);
      flush = 1'b0;
      settle();
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn  = 1'b0;
    flush = 1'b0;
    drive_req(1'b0, '0, '0, '0);
    drive_dm(1'b0, 1'b0, '0);
    model_reset();

    // Reset values
    #12;
    chk("rst_up_ready", dm_out.dmem_ready, 1'b1);
    chk("rst_up_resp",  dm_out.resp, '0);
    chk("rst_down",     ptw_out, '0);
    chk("rst_busy",     busy, 1'b0);
    chk("rst_timeout",  tmo, 1'b0);
    chk("rst_state",    st, ST_IDLE);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single load, adapter ready
    drive_req(1'b1, 40'h80_0000_1008, 5'b00000, '0);
    drive_dm(1'b1, 1'b0, '0);
    settle();
    chk("t1_up_ready_c0", dm_out.dmem_ready, 1'b1);
    tick();
    drive_req(1'b0, '0, '0, '0);
    settle();
    chk("t1_down_valid_c1", ptw_out.req.valid, 1'b1);
    chk("t1_down_addr_c1",  ptw_out.req.addr, 40'h80_0000_1008);
    tick();
    drive_dm(1'b0, 1'b0, '0);
    for (int i = 2; i < 5; i++) begin settle(); tick(); end
    drive_dm(1'b0, 1'b1, 64'hDEAD_BEEF);
    settle();
    chk("t1_resp_valid_c5", dm_out.resp.valid, 1'b1);
    chk("t1_resp_data_c5",  dm_out.resp.data, 64'hDEAD_BEEF);
    tick();
    drive_dm(1'b0, 1'b0, '0);
    settle();
    chk("t1_busy_c6", busy, 1'b0);
    tick();

    // Adapter backpressure for 3 cycles
    drive_req(1'b1, 40'h12_3456_7890, 5'b00000, '0);
    drive_dm(1'b0, 1'b0, '0);
    settle(); tick();
    drive_req(1'b1, 40'h55_5555_5555, 5'b00001, 64'h1);
    for (int i = 0; i < 4; i++) begin
      drive_dm(i == 3, 1'b0, '0);
      settle();
      chk("t2_down_valid", ptw_out.req.valid, 1'b1);
      chk("t2_down_addr",  ptw_out.req.addr, 40'h12_3456_7890);
      chk("t2_up_ready",   dm_out.dmem_ready, 1'b0);
      tick();
    end
    drive_req(1'b0, '0, '0, '0);
    drive_dm(1'b0, 1'b1, 64'h77);
    settle(); tick();

    // AMO_OR, response 10 cycles after the handshake
    drive_req(1'b1, 40'h00_0000_2040, 5'b01010, 64'h40);
    drive_dm(1'b1, 1'b0, '0);
    settle(); tick();
    drive_req(1'b0, '0, '0, '0);
    settle();
    chk("t3_down_cmd",  ptw_out.req.cmd, 5'b01010);
    chk("t3_down_data", ptw_out.req.data, 64'h40);
    tick();
    drive_dm(1'b0, 1'b0, '0);
    for (int i = 0; i < 9; i++) begin
      settle();
      chk("t3_addr_held", ptw_out.req.addr, 40'h00_0000_2040);
      tick();
    end
    drive_dm(1'b0, 1'b1, 64'h0000_0000_0000_00C0);
    settle();
    chk("t3_resp_data", dm_out.resp.data, 64'hC0);
    tick();

    // Flush in WAIT, response arrives later and is discarded
    drive_req(1'b1, 40'h00_0000_3000, 5'b00000, '0);
    drive_dm(1'b1, 1'b0, '0);
    settle(); tick();
    drive_req(1'b0, '0, '0, '0);
    settle(); tick();
    drive_dm(1'b0, 1'b0, '0);
    settle(); tick();
    flush = 1'b1;
    settle(); tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin settle(); tick(); end
    drive_dm(1'b0, 1'b1, 64'hBAD);
    settle();
    chk("t4_no_resp", dm_out.resp.valid, 1'b0);
    tick();
    drive_dm(1'b0, 1'b0, '0);
    settle();
    chk("t4_idle_after", busy, 1'b0);
    tick();
    drive_req(1'b1, 40'h00_0000_3008, 5'b00000, '0);
    drive_dm(1'b1, 1'b0, '0);
    settle(); tick();
    drive_req(1'b0, '0, '0, '0);
    settle(); tick();
    drive_dm(1'b0, 1'b1, 64'h600D);
    settle();
    chk("t4_next_resp", dm_out.resp.data, 64'h600D);
    tick();

    // Flush in REQ with adapter ready in the same cycle
    drive_req(1'b1, 40'h00_0000_4000, 5'b00000, '0);
    drive_dm(1'b1, 1'b0, '0);
    settle(); tick();
    drive_req(1'b0, '0, '0, '0);
    flush = 1'b1;
    settle();
    chk("t5_down_valid", ptw_out.req.valid, 1'b0);
    tick();
    flush = 1'b0;
    drive_dm(1'b0, 1'b1, 64'h5757);
    settle();
    chk("t5_idle", busy, 1'b0);
    chk("t5_stray_dropped", dm_out.resp.valid, 1'b0);
    tick();
    idle_cycles(1);

`ifdef MMU_PTW_DMEM_TIMEOUT_EN
    // Timeout: request cycle 0, handshake cycle 1, timeout cycle 17,
    // late response cycle 30, idle cycle 31
    drive_req(1'b1, 40'h00_0000_5000, 5'b00000, '0);
    drive_dm(1'b1, 1'b0, '0);
    settle(); tick();
    drive_req(1'b0, '0, '0, '0);
    settle(); tick();
    drive_dm(1'b0, 1'b0, '0);
    for (int c = 2; c < 30; c++) begin
      settle();
      chk("t6_timeout_pulse", tmo, c == 17);
      tick();
    end
    drive_dm(1'b0, 1'b1, 64'hAAAA);
    settle();
    chk("t6_late_dropped", dm_out.resp.valid, 1'b0);
    tick();
    drive_dm(1'b0, 1'b0, '0);
    settle();
    chk("t6_idle_c31", st, ST_IDLE);
    tick();
`endif

    // Asynchronous reset during WAIT, stray response afterwards
    drive_req(1'b1, 40'h00_0000_6000, 5'b00000, '0);
    drive_dm(1'b1, 1'b0, '0);
    settle(); tick();
    drive_req(1'b0, '0, '0, '0);
    settle(); tick();
    drive_dm(1'b0, 1'b0, '0);
    settle();
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_busy",  busy, 1'b0);
    chk("rst_mid_state", st, ST_IDLE);
    chk("rst_mid_down",  ptw_out, '0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    drive_dm(1'b0, 1'b1, 64'hDEAD);
    settle();
    chk("rst_stray_dropped", dm_out.resp.valid, 1'b0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive_req($urandom_range(0, 1) == 1, {8'h0, $urandom}, 5'($urandom_range(0, 31)),
                {$urandom, $urandom});
      drive_dm($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, {$urandom, $urandom});
      flush = ($urandom_range(0, 9) == 0);
      settle();
      tick();
    end
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
